// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
//   Walks the register list of an LM/SM instruction and issues one register
//   transfer per cycle, lowest register index first, at consecutive memory
//   addresses. While transfers are outstanding the front end is held via
//   o_busy. A one-cycle o_done pulse closes every accepted operation,
//   including an empty list.
//
//   All outputs are registered. They are loaded from the next-state values,
//   so a start sampled at the end of cycle 0 shows its first transfer during
//   cycle 1.
//
// Optional feature (compile-time macro LMSM_R7_MASK_EN):
//   When defined, bit 7 of the list (R7 = PC) is stripped at latch time and
//   o_r7_dropped reports whether it was set. When undefined, R7 is an
//   ordinary register and o_r7_dropped stays 0.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset; aborts an operation at once
//   i_start        operation accepted from decode (sampled only when idle)
//   i_is_lm        1 = LM (mem -> reg), 0 = SM (reg -> mem); latched at start
//   i_reg_list     bit i set = transfer Ri; latched at start
//   i_base_addr    first memory address; latched at start
//   i_stall        downstream hold; the current transfer is not consumed
//   o_busy         sequencer owns the regfile/memory ports
//   o_xfer_valid   o_reg_addr/o_mem_addr describe a live transfer
//   o_reg_addr     register index of the current transfer
//   o_mem_addr     memory address of the current transfer
//   o_reg_we       regfile write enable (LM transfers)
//   o_mem_we       memory write enable (SM transfers)
//   o_done         one-cycle completion pulse
//   o_r7_dropped   R7 was masked out of the current/last operation
// -----------------------------------------------------------------------------
module lmsm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int NREGS     = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_is_lm,
  input  logic [NREGS-1:0]  i_reg_list,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_xfer_valid,
  output logic [2:0]        o_reg_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_reg_we,
  output logic              o_mem_we,
  output logic              o_done,
  output logic              o_r7_dropped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NREGS-1:0]  r_pending, w_pending_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_op, w_op_nxt;
  logic              r_r7, w_r7_nxt;
  logic [NREGS-1:0]  w_latch_list;
  logic              w_r7_hit;
  logic              w_issue_nxt;

  // Priority encoder: index of the lowest set bit (0 when the mask is empty).
  function automatic logic [2:0] lowest_idx(input logic [NREGS-1:0] mask);
    lowest_idx = 3'd0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_idx = i[2:0];
      end
    end
  endfunction

`ifdef LMSM_R7_MASK_EN
  localparam logic [NREGS-1:0] R7_BIT = NREGS'(1) << 7;
  assign w_latch_list = i_reg_list & ~R7_BIT;
  assign w_r7_hit     = i_reg_list[7];
`else
  assign w_latch_list = i_reg_list;
  assign w_r7_hit     = 1'b0;
`endif

  // Next-state logic: latch on start, consume one list bit per unstalled cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_ptr_nxt     = r_ptr;
    w_op_nxt      = r_op;
    w_r7_nxt      = r_r7;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_pending_nxt = w_latch_list;
          w_ptr_nxt     = i_base_addr;
          w_op_nxt      = i_is_lm;
          w_r7_nxt      = w_r7_hit;
          if (w_latch_list == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!i_stall) begin
          // m & (m-1) clears exactly the lowest set bit
          w_pending_nxt = r_pending & (r_pending - NREGS'(1));
          w_ptr_nxt     = r_ptr + ADDR_W'(ADDR_STEP);
          if ((r_pending & (r_pending - NREGS'(1))) == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_issue_nxt = (w_state_nxt == ST_ISSUE);

  // Sequencer state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_ptr     <= '0;
      r_op      <= 1'b0;
      r_r7      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_ptr     <= w_ptr_nxt;
      r_op      <= w_op_nxt;
      r_r7      <= w_r7_nxt;
    end
  end

  // Output registers, loaded from next-state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy       <= 1'b0;
      o_xfer_valid <= 1'b0;
      o_reg_addr   <= 3'd0;
      o_mem_addr   <= '0;
      o_reg_we     <= 1'b0;
      o_mem_we     <= 1'b0;
      o_done       <= 1'b0;
      o_r7_dropped <= 1'b0;
    end else begin
      o_busy       <= w_issue_nxt;
      o_xfer_valid <= w_issue_nxt;
      o_reg_addr   <= w_issue_nxt ? lowest_idx(w_pending_nxt) : 3'd0;
      o_mem_addr   <= w_issue_nxt ? w_ptr_nxt : '0;
      o_reg_we     <= w_issue_nxt & w_op_nxt;
      o_mem_we     <= w_issue_nxt & ~w_op_nxt;
      o_done       <= (w_state_nxt == ST_DONE);
      o_r7_dropped <= w_r7_nxt;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lmsm_sequencer
//   Self-checking bench for lmsm_sequencer: a table of directed operations,
//   hand-written reset-abort and start-while-busy sequences, and randomized
//   operations compared cycle by cycle against a queue-based transfer model.
//   Honours LMSM_R7_MASK_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, is_lm, stall;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        busy, xv, reg_we, mem_we, done, r7;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lmsm_sequencer #(.ADDR_W(16), .NREGS(8), .ADDR_STEP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_lm(is_lm),
    .i_reg_list(reg_list), .i_base_addr(base_addr), .i_stall(stall),
    .o_busy(busy), .o_xfer_valid(xv), .o_reg_addr(reg_addr),
    .o_mem_addr(mem_addr), .o_reg_we(reg_we), .o_mem_we(mem_we),
    .o_done(done), .o_r7_dropped(r7)
  );

`ifdef LMSM_R7_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        xv;
    logic [2:0]  ra;
    logic [15:0] ma;
    logic        rwe;
    logic        mwe;
    logic        done;
    logic        r7;
  } outs_t;

  typedef struct {
    logic        lm;
    logic [7:0]  list;
    logic [15:0] base;
    logic [15:0] stalls;     // bit k = stall during cycle k
    int          exp_valid;  // cycles with xfer_valid (stalls included)
    int          exp_done;   // cycle of the done pulse
    logic [2:0]  exp_last_reg;
    logic [15:0] exp_last_mem;
    logic        exp_r7;
  } vec_t;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
  } xfer_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t cur_outs();
    return '{busy, xv, reg_addr, mem_addr, reg_we, mem_we, done, r7};
  endfunction

  function automatic outs_t idle_outs(input logic r7v);
    return '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, r7v};
  endfunction

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = cur_outs();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy=%b xv=%b ra=%0d ma=%h rwe=%b mwe=%b done=%b r7=%b, expected busy=%b xv=%b ra=%0d ma=%h rwe=%b mwe=%b done=%b r7=%b",
               name, act.busy, act.xv, act.ra, act.ma, act.rwe, act.mwe, act.done, act.r7,
               exp.busy, exp.xv, exp.ra, exp.ma, exp.rwe, exp.mwe, exp.done, exp.r7);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue_start(input logic lm, input logic [7:0] list, input logic [15:0] base);
    start = 1'b1; is_lm = lm; reg_list = list; base_addr = base;
    step();
    start = 1'b0;
  endtask

  // Directed vector: run 13 cycles after the start and summarize what was seen.
  task automatic run_vec(input int v, input vec_t t);
    int valid_cnt = 0, busy_cnt = 0, done_cnt = 0, first_done = -1, we_err = 0;
    logic [2:0]  last_reg = 3'd0;
    logic [15:0] last_mem = 16'h0000;
    issue_start(t.lm, t.list, t.base);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (xv) begin
        valid_cnt++;
        last_reg = reg_addr;
        last_mem = mem_addr;
        if (reg_we !== t.lm || mem_we !== !t.lm) we_err++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      stall = t.stalls[cyc];
      step();
    end
    stall = 1'b0;
    check_int($sformatf("vec%0d_valid_cycles", v), valid_cnt, t.exp_valid);
    check_int($sformatf("vec%0d_busy_cycles", v), busy_cnt, t.exp_valid);
    check_int($sformatf("vec%0d_done_cycle", v), first_done, t.exp_done);
    check_int($sformatf("vec%0d_done_pulses", v), done_cnt, 1);
    check_int($sformatf("vec%0d_we_errors", v), we_err, 0);
    check_int($sformatf("vec%0d_last_reg", v), int'(last_reg), int'(t.exp_last_reg));
    check_int($sformatf("vec%0d_last_mem", v), int'(last_mem), int'(t.exp_last_mem));
    check_int($sformatf("vec%0d_r7_dropped", v), int'(r7), int'(t.exp_r7));
  endtask

  // Random operation checked against a transfer queue built from the list.
  task automatic run_rand_op(input int k);
    xfer_t       q[$];
    logic        lm = 1'($urandom);
    logic [7:0]  list;
    logic [15:0] base;
    logic [15:0] addr;
    logic [7:0]  eff;
    logic        exp_r7;
    int          guard = 0;
    logic        st;
    case ($urandom_range(0, 5))
      0:       list = 8'h00;
      1:       list = 8'hFF;
      2:       list = 8'h80;
      default: list = 8'($urandom);
    endcase
    base = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
    eff    = MASK ? (list & 8'h7F) : list;
    exp_r7 = MASK & list[7];
    addr   = base;
    for (int i = 0; i < 8; i++) begin
      if (eff[i]) begin
        q.push_back('{3'(i), addr});
        addr = addr + 16'd1;
      end
    end
    issue_start(lm, list, base);
    while (q.size() > 0 && guard < 200) begin
      check_outs($sformatf("rand%0d_xfer", k),
                 '{1'b1, 1'b1, q[0].r, q[0].a, lm, !lm, 1'b0, exp_r7});
      st = ($urandom_range(0, 3) == 0);
      stall = st;
      start = 1'($urandom); is_lm = 1'($urandom);
      reg_list = 8'($urandom); base_addr = 16'($urandom);
      step();
      if (!st) void'(q.pop_front());
      guard++;
    end
    check_int($sformatf("rand%0d_guard", k), int'(guard < 200), 1);
    check_outs($sformatf("rand%0d_done", k),
               '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, exp_r7});
    stall = 1'($urandom);
    start = 1'($urandom); reg_list = 8'($urandom);
    step();
    start = 1'b0; stall = 1'b0;
    check_outs($sformatf("rand%0d_idle", k), idle_outs(exp_r7));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_lm = 1'b0; stall = 1'b0;
    reg_list = 8'h00; base_addr = 16'h0000;

    vecs[0] = '{1'b1, 8'b0010_0101, 16'h0040, 16'h0000, 3, 4, 3'd5, 16'h0042, 1'b0};
    vecs[1] = MASK ? '{1'b0, 8'hFF, 16'hFFFE, 16'h0000, 7, 8, 3'd6, 16'h0004, 1'b1}
                   : '{1'b0, 8'hFF, 16'hFFFE, 16'h0000, 8, 9, 3'd7, 16'h0005, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 16'h1234, 16'h0000, 0, 1, 3'd0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 8'h12, 16'h0100, 16'h0002, 3, 4, 3'd4, 16'h0101, 1'b0};
    vecs[4] = MASK ? '{1'b0, 8'h80, 16'h0010, 16'h0000, 0, 1, 3'd0, 16'h0000, 1'b1}
                   : '{1'b0, 8'h80, 16'h0010, 16'h0000, 1, 2, 3'd7, 16'h0010, 1'b0};
    vecs[5] = MASK ? '{1'b1, 8'h81, 16'hFFFF, 16'h0000, 1, 2, 3'd0, 16'hFFFF, 1'b1}
                   : '{1'b1, 8'h81, 16'hFFFF, 16'h0000, 2, 3, 3'd7, 16'h0000, 1'b0};

    step(); step(); step();
    rst = 1'b0;
    check_outs("reset_state", idle_outs(1'b0));
    step();
    check_outs("idle_no_start", idle_outs(1'b0));

    for (int v = 0; v < 6; v++) begin
      run_vec(v, vecs[v]);
    end

    // Stall in cycle 1 repeats R1@base, then R4@base+1.
    issue_start(1'b1, 8'h12, 16'h0200);
    check_outs("stall_c1", '{1'b1, 1'b1, 3'd1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0});
    stall = 1'b1; step(); stall = 1'b0;
    check_outs("stall_c2_repeat", '{1'b1, 1'b1, 3'd1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    check_outs("stall_c3", '{1'b1, 1'b1, 3'd4, 16'h0201, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    check_outs("stall_c4_done", '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    step();

    // Reset mid-op aborts immediately; next start is accepted.
    issue_start(1'b0, 8'h0F, 16'h0300);
    check_outs("rstabort_c1", '{1'b1, 1'b1, 3'd0, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0});
    step();
    check_outs("rstabort_c2", '{1'b1, 1'b1, 3'd1, 16'h0301, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b1; step(); rst = 1'b0;
    check_outs("rstabort_c3_zero", idle_outs(1'b0));
    issue_start(1'b1, 8'h02, 16'h0400);
    check_outs("rstabort_new_xfer", '{1'b1, 1'b1, 3'd1, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    check_outs("rstabort_new_done", '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    step();

    // start re-asserted while busy is ignored.
    issue_start(1'b1, 8'h06, 16'h0050);
    check_outs("busy_start_c1", '{1'b1, 1'b1, 3'd1, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0});
    start = 1'b1; is_lm = 1'b0; reg_list = 8'hFF; base_addr = 16'h0000;
    step();
    check_outs("busy_start_c2", '{1'b1, 1'b1, 3'd2, 16'h0051, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    start = 1'b0;
    check_outs("busy_start_c3_done", '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    check_outs("busy_start_c4_idle", idle_outs(1'b0));

    for (int k = 0; k < 40; k++) begin
      run_rand_op(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
